// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - parametrised VGA timing generator with pixel enable
// Define VGA_TESTPAT_EN to add a registered 8-bar RGB test pattern output.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CW       = 10
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CE,
  output logic          H_pulse,
  output logic          V_pulse,
  output logic          ACTIVE,
  output logic [CW-1:0] COL,
  output logic [CW-1:0] ROW,
  output logic          LINE_START,
  output logic          FRAME_START
`ifdef VGA_TESTPAT_EN
  ,
  output logic [11:0]   RGB
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (1 << CW)) begin : g_h_total_chk
    $error("vga_sync_gen: H_TOTAL exceeds 2**CW");
  end
  if (V_TOTAL > (1 << CW)) begin : g_v_total_chk
    $error("vga_sync_gen: V_TOTAL exceeds 2**CW");
  end

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          H_ON     = (H_POL != 0);
  localparam logic          V_ON     = (V_POL != 0);

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          act_q, act_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;

  // Every output is decoded from the next count so it lines up with COL/ROW.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (CE) begin
      if (col_q == H_LAST) begin
        col_d = '0;
        row_d = (row_q == V_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    hs_d  = (col_d >= HS_FIRST && col_d <= HS_LAST) ? H_ON : ~H_ON;
    vs_d  = (row_d >= VS_FIRST && row_d <= VS_LAST) ? V_ON : ~V_ON;
    act_d = (col_d < H_ACT) && (row_d < V_ACT);
    ls_d  = CE && (col_d == '0);
    fs_d  = ls_d && (row_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      col_q <= H_LAST;
      row_q <= V_LAST;
      hs_q  <= ~H_ON;
      vs_q  <= ~V_ON;
      act_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      act_q <= act_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  assign COL         = col_q;
  assign ROW         = row_q;
  assign H_pulse     = hs_q;
  assign V_pulse     = vs_q;
  assign ACTIVE      = act_q;
  assign LINE_START  = ls_q;
  assign FRAME_START = fs_q;

`ifdef VGA_TESTPAT_EN
  localparam int BW = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [CW-1:0] BW_LAST = CW'(BW - 1);

  logic [CW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]    bar_q, bar_d;
  logic [11:0]   rgb_q, rgb_d;

  // Bar index tracks col_d; it saturates at the last bar so any remainder stays black.
  always_comb begin
    bar_cnt_d = bar_cnt_q;
    bar_d     = bar_q;
    if (CE) begin
      if (col_d == '0) begin
        bar_cnt_d = '0;
        bar_d     = 3'd0;
      end else if (bar_cnt_q == BW_LAST) begin
        bar_cnt_d = '0;
        if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + 1'b1;
      end
    end
    rgb_d = 12'h000;
    if (act_d) begin
      case (bar_d)
        3'd0:    rgb_d = 12'hFFF;
        3'd1:    rgb_d = 12'hFF0;
        3'd2:    rgb_d = 12'h0FF;
        3'd3:    rgb_d = 12'h0F0;
        3'd4:    rgb_d = 12'hF0F;
        3'd5:    rgb_d = 12'hF00;
        3'd6:    rgb_d = 12'h00F;
        default: rgb_d = 12'h000;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      bar_cnt_q <= '0;
      bar_q     <= 3'd0;
      rgb_q     <= 12'h000;
    end else begin
      bar_cnt_q <= bar_cnt_d;
      bar_q     <= bar_d;
      rgb_q     <= rgb_d;
    end
  end

  assign RGB = rgb_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - randomized self-checking bench for vga_sync_gen
// Three configurations share CLK/CE/RST_N; expectations come from a frame-position model.
module tb_vga_sync_gen;

  logic CLK = 1'b0;
  logic RST_N;
  logic CE;

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int n      = 0;
  bit lce    = 1'b0;

  logic       a_hs, a_vs, a_act, a_ls, a_fs;
  logic [9:0] a_col, a_row;
  logic       b_hs, b_vs, b_act, b_ls, b_fs;
  logic [3:0] b_col, b_row;
  logic       c_hs, c_vs, c_act, c_ls, c_fs;
  logic [5:0] c_col, c_row;
`ifdef VGA_TESTPAT_EN
  logic [11:0] a_rgb, b_rgb, c_rgb;
`endif

  vga_sync_gen u_def (
    .CLK(CLK), .RST_N(RST_N), .CE(CE),
    .H_pulse(a_hs), .V_pulse(a_vs), .ACTIVE(a_act), .COL(a_col), .ROW(a_row),
    .LINE_START(a_ls), .FRAME_START(a_fs)
`ifdef VGA_TESTPAT_EN
    , .RGB(a_rgb)
`endif
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1), .V_POL(0), .CW(4)
  ) u_small (
    .CLK(CLK), .RST_N(RST_N), .CE(CE),
    .H_pulse(b_hs), .V_pulse(b_vs), .ACTIVE(b_act), .COL(b_col), .ROW(b_row),
    .LINE_START(b_ls), .FRAME_START(b_fs)
`ifdef VGA_TESTPAT_EN
    , .RGB(b_rgb)
`endif
  );

  vga_sync_gen #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .H_POL(0), .V_POL(1), .CW(6)
  ) u_mid (
    .CLK(CLK), .RST_N(RST_N), .CE(CE),
    .H_pulse(c_hs), .V_pulse(c_vs), .ACTIVE(c_act), .COL(c_col), .ROW(c_row),
    .LINE_START(c_ls), .FRAME_START(c_fs)
`ifdef VGA_TESTPAT_EN
    , .RGB(c_rgb)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, n, obs, exp);
    end
  endtask

  // The model places the frame at index (n-1) mod total, n = CE edges since reset.
  task automatic check_cfg(input string tag,
                           input int ha, input int hf, input int hs, input int hb,
                           input int va, input int vf, input int vs, input int vb,
                           input int hp, input int vp,
                           input int col, input int row,
                           input bit o_hs, input bit o_vs, input bit o_act,
                           input bit o_ls, input bit o_fs, input int o_rgb);
    int ht, vt, total, p, ecol, erow, bw, idx, ergb;
    int bars[8];
    bars = '{'hFFF, 'hFF0, 'h0FF, 'h0F0, 'hF0F, 'hF00, 'h00F, 'h000};
    ht    = ha + hf + hs + hb;
    vt    = va + vf + vs + vb;
    total = ht * vt;
    p     = (n + total - 1) % total;
    ecol  = p % ht;
    erow  = p / ht;
    chk({tag, ".col"}, col, ecol);
    chk({tag, ".row"}, row, erow);
    chk({tag, ".hsync"}, int'(o_hs),
        (ecol >= ha + hf && ecol < ha + hf + hs) ? hp : 1 - hp);
    chk({tag, ".vsync"}, int'(o_vs),
        (erow >= va + vf && erow < va + vf + vs) ? vp : 1 - vp);
    chk({tag, ".active"}, int'(o_act), (ecol < ha && erow < va) ? 1 : 0);
    chk({tag, ".line_start"}, int'(o_ls), (lce && ecol == 0) ? 1 : 0);
    chk({tag, ".frame_start"}, int'(o_fs), (lce && ecol == 0 && erow == 0) ? 1 : 0);
    bw   = (ha / 8 > 0) ? ha / 8 : 1;
    idx  = ecol / bw;
    if (idx > 7) idx = 7;
    ergb = (ecol < ha && erow < va) ? bars[idx] : 0;
`ifdef VGA_TESTPAT_EN
    chk({tag, ".rgb"}, o_rgb, ergb);
`endif
  endtask

  task automatic cycle(input bit rst_n, input bit ce);
    int ra, rb, rc;
    @(negedge CLK);
    RST_N = rst_n;
    CE    = ce;
    @(posedge CLK);
    if (!rst_n) begin
      n   = 0;
      lce = 1'b0;
    end else if (ce) begin
      n++;
      lce = 1'b1;
    end else begin
      lce = 1'b0;
    end
    #1;
    ra = 0; rb = 0; rc = 0;
`ifdef VGA_TESTPAT_EN
    ra = int'(a_rgb); rb = int'(b_rgb); rc = int'(c_rgb);
`endif
    check_cfg("def", 640, 16, 96, 48, 480, 10, 2, 33, 0, 0,
              int'(a_col), int'(a_row), a_hs, a_vs, a_act, a_ls, a_fs, ra);
    check_cfg("small", 8, 2, 3, 1, 4, 1, 1, 1, 1, 0,
              int'(b_col), int'(b_row), b_hs, b_vs, b_act, b_ls, b_fs, rb);
    check_cfg("mid", 20, 3, 4, 5, 10, 2, 3, 2, 0, 1,
              int'(c_col), int'(c_row), c_hs, c_vs, c_act, c_ls, c_fs, rc);
  endtask

  initial begin
    RST_N = 1'b0;
    CE    = 1'b1;
    repeat (5) cycle(1'b0, 1'b1);
    repeat (1700) cycle(1'b1, 1'b1);
    for (int i = 0; i < 3400; i++) cycle(1'b1, (i % 2) == 1);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 4000; i++)
      cycle(($urandom % 300) != 0, ($urandom % 4) != 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Parametrised VGA timing generator; successor to the fixed 640x480 sync pulse block. Porch, sync and active lengths, and sync polarities, are parameters. Adds a pixel clock-enable, active-video flag, pixel column/row coordinates and frame/line start strobes. Sits between the board clock and the pixel/colour pipeline that drives the VGA DAC pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, H_pulse asserted level (0 = active-low)
V_POL, 0, V_pulse asserted level (0 = active-low)
CW, 10, width of COL/ROW counters

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  synchronous reset, active-low
CE  in  1  pixel enable; counters advance only on CLK edges with CE=1
H_pulse  out  1  horizontal sync
V_pulse  out  1  vertical sync
ACTIVE  out  1  high while (COL,ROW) is in the visible region
COL  out  CW  current pixel column, 0..H_TOTAL-1
ROW  out  CW  current line, 0..V_TOTAL-1
LINE_START  out  1  one-CLK strobe on entry to COL=0
FRAME_START  out  1  one-CLK strobe on entry to COL=0,ROW=0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525). Elaboration must fail if H_TOTAL or V_TOTAL exceeds 2^CW.
- Reset (RST_N=0 at a CLK edge, regardless of CE): COL=H_TOTAL-1, ROW=V_TOTAL-1, H_pulse=~H_POL, V_pulse=~V_POL, ACTIVE=0, LINE_START=0, FRAME_START=0. Reset mid-frame takes effect on that edge with no partial state retained.
- Counting (CE=1): COL increments and wraps H_TOTAL-1 -> 0. On that wrap ROW increments and wraps V_TOTAL-1 -> 0. The first CE edge after reset therefore lands on (0,0).
- CE=0: COL, ROW, H_pulse, V_pulse and ACTIVE hold. LINE_START and FRAME_START are forced to 0.
- All outputs are registered, decoded from next-count values, so every output is consistent with COL/ROW in the same cycle (zero skew, no combinational outputs).
- H_pulse = H_POL iff H_ACTIVE+H_FP <= COL <= H_ACTIVE+H_FP+H_SYNC-1; otherwise ~H_POL.
- V_pulse = V_POL iff V_ACTIVE+V_FP <= ROW <= V_ACTIVE+V_FP+V_SYNC-1; otherwise ~V_POL. V_pulse changes on the same edge COL wraps to 0.
- ACTIVE = (COL < H_ACTIVE) && (ROW < V_ACTIVE).
- LINE_START = 1 for exactly the CLK cycle following a CE edge that produced COL=0. FRAME_START is the same, additionally requiring ROW=0.
- No state machine beyond the two wrap counters. Sync and active decodes use compares against constant parameter expressions; no dividers.

Optional Feature:
VGA_TESTPAT_EN: when defined, adds output RGB [11:0] (4:4:4). While ACTIVE, RGB shows 8 vertical colour bars, each H_ACTIVE/8 pixels wide, left to right: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000. Outside ACTIVE and in reset, RGB=000. RGB is registered and aligned with ACTIVE/COL. The bar index comes from a bar-width sub-counter, not a divider. When the macro is undefined, the RGB port and its logic are absent and all other behaviour is identical.

Test Plan:
1. Defaults, CE=1, RST_N low 5 cycles -> COL=799, ROW=524, H_pulse=1, V_pulse=1, ACTIVE=0, strobes 0. First edge after release -> COL=0, ROW=0, ACTIVE=1, LINE_START=1, FRAME_START=1, both strobes 0 the next cycle.
2. Horizontal timing, defaults -> H_pulse low exactly 96 cycles starting at COL=656. Falling edges 800 cycles apart. ACTIVE high for COL 0..639 on rows 0..479.
3. Vertical timing, defaults -> V_pulse low for ROW 490..491 (1600 CLK). FRAME_START period 420000 CLK. Exactly one FRAME_START and 525 LINE_STARTs per frame.
4. CE asserted every 2nd cycle -> line period 1600 CLK. All outputs stable during CE=0 cycles. Strobes one CLK wide.
5. RST_N pulsed low one cycle at ROW=200, COL=300 -> next edge shows reset values. Restart from (0,0) on the following CE edge.
6. H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, H_POL=1, VGA_TESTPAT_EN defined -> H_pulse high at COL 10..12, line period 14 CLK. V_pulse low on ROW 5 only. RGB = FFF at COL 0, FF0 at COL 1, 000 at COL 7 and at COL >= 8.
